inst_buffer: RTL and testbench
==============================

INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter IW, default 9: instruction word width in bits.
REQ-002 Parameter DEPTH, default 4: entry count; SHALL be a power of two, at least 2.
REQ-003 Port CLK, input, 1: single clock; all state changes on posedge CLK only.
REQ-004 Port Reset, input, 1: asynchronous, active-high reset.
REQ-005 Port PC, input, 16: address of the fetched word, from the fetch stage.
REQ-006 Port InstIn, input, IW: instruction word read from instruction ROM at PC.
REQ-007 Port FetchValid, input, 1: PC and InstIn are valid this cycle.
REQ-008 Port FetchReady, output, 1: buffer accepts a word this cycle.
REQ-009 Port Halt, output, 1: freezes the fetch-stage PC; equals NOT FetchReady.
REQ-010 Port Flush, input, 1: branch/jump taken; discard all buffered words.
REQ-011 Port DecodeReady, input, 1: decode consumes the head entry this cycle.
REQ-012 Port InstValid, output, 1: head entry present.
REQ-013 Port InstOut, output, IW: instruction word of the head entry.
REQ-014 Port PCOut, output, 16: PC of the head entry.
REQ-015 Port Count, output, log2(DEPTH)+1: number of occupied entries, 0..DEPTH.
REQ-016 Port DropCnt, output, 8: words discarded by Flush, saturating.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries, each {PC, InstIn}, addressed by write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 Push SHALL occur when FetchValid=1, FetchReady=1 and Flush=0: write the entry at the write pointer and advance the write pointer by 1.
REQ-019 Pop SHALL occur when InstValid=1, DecodeReady=1 and Flush=0: advance the read pointer by 1.
REQ-020 On simultaneous push and pop, Count SHALL remain unchanged and both pointers SHALL advance.
REQ-021 FetchReady SHALL be (Count < DEPTH) as a registered-state decode, with no combinational path from DecodeReady, FetchValid or Flush.
REQ-022 When full, a same-cycle pop SHALL NOT enable a push.
REQ-023 InstValid SHALL be (Count != 0).
REQ-024 InstOut and PCOut SHALL show the head entry combinationally (show-ahead), and SHALL be all zeros when Count = 0.
REQ-025 A head entry held with DecodeReady=0 SHALL keep InstOut, PCOut and InstValid stable until it is popped or flushed.
REQ-026 Flush SHALL be synchronous and take effect on the next edge: Count = 0, both pointers = 0, and any same-cycle push or pop is ignored.
REQ-027 On Flush, DropCnt SHALL increase by the Count value held before that edge, saturating at 255; Flush with Count = 0 leaves DropCnt unchanged.
REQ-028 FetchValid=1 while FetchReady=0 SHALL NOT change any state; the word is lost, and the fetch stage holds PC via Halt.
REQ-029 Entry order SHALL be strict FIFO; no entry is duplicated or reordered across pointer wrap-around.
REQ-030 Count SHALL never exceed DEPTH and never go below 0 under any input sequence.

Reset
REQ-031 While Reset=1, outputs SHALL be immediately: Count=0, DropCnt=0, InstValid=0, InstOut=0, PCOut=0, FetchReady=1, Halt=0.
REQ-032 Reset SHALL set both pointers to 0 and override Flush, push and pop.
REQ-033 Storage contents need no reset; no output may expose storage contents while Count = 0.
REQ-034 Reset asserted mid-operation SHALL discard all entries without incrementing DropCnt.
REQ-035 Deassertion of Reset SHALL be followed by normal operation from the first subsequent posedge CLK.

Verification (DEPTH=4, IW=9)
REQ-036 Fill: push PC 0..3 with words 0x101..0x104 while DecodeReady=0 -> Count=4, FetchReady=0, Halt=1, InstOut=0x101, PCOut=0.
REQ-037 Full plus pop: with the buffer full, FetchValid=1 and DecodeReady=1 for one cycle -> Count=3, no push, next InstOut=0x102.
REQ-038 Wrap-around: 10 consecutive pushes with a pop every cycle starting cycle 2 -> PCOut sequence 0..9 in order, Count never above 2.
REQ-039 Flush: with Count=3 and DropCnt=0, assert Flush together with push and pop -> next cycle Count=0, InstValid=0, InstOut=0, DropCnt=3.
REQ-040 Saturation: 86 flushes of a full buffer -> DropCnt=255, and further flushes keep it at 255.
REQ-041 Async reset: assert Reset between clock edges with Count=2 -> Count=0, InstValid=0 and FetchReady=1 before the next edge, DropCnt unchanged at 0.

Source files
------------

// File: rtl/inst_buffer_if.sv
// Fetch/decode handshake bundle for the instruction buffer.
// The master side is fetch+decode; the slave side is the buffer itself.
interface inst_buffer_if #(
  parameter int IW    = 9,
  parameter int DEPTH = 4
);
  logic [15:0]              PC;
  logic [IW-1:0]            InstIn;
  logic                     FetchValid;
  logic                     FetchReady;
  logic                     Halt;
  logic                     Flush;
  logic                     DecodeReady;
  logic                     InstValid;
  logic [IW-1:0]            InstOut;
  logic [15:0]              PCOut;
  logic [$clog2(DEPTH):0]   Count;
  logic [7:0]               DropCnt;

  modport master (
    output PC, InstIn, FetchValid, Flush, DecodeReady,
    input  FetchReady, Halt, InstValid, InstOut, PCOut, Count, DropCnt
  );

  modport slave (
    input  PC, InstIn, FetchValid, Flush, DecodeReady,
    output FetchReady, Halt, InstValid, InstOut, PCOut, Count, DropCnt
  );
endinterface

// File: rtl/inst_buffer.sv
// Show-ahead circular instruction buffer between fetch and decode,
// with synchronous flush and a saturating count of flushed words.
module inst_buffer #(
  parameter int IW    = 9,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  inst_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [15:0]   pc;
    logic [IW-1:0] inst;
  } ent_t;

  ent_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_drop;

  logic          w_ready, w_valid, w_push, w_pop;
  logic [8:0]    w_drop_sum;
  ent_t          w_head;

  // Ready decodes registered state only, so a same-cycle pop never frees a slot.
  assign w_ready    = (r_count != CW'(DEPTH));
  assign w_valid    = (r_count != '0);
  assign w_push     = bus.FetchValid & w_ready & ~bus.Flush;
  assign w_pop      = bus.DecodeReady & w_valid & ~bus.Flush;
  assign w_drop_sum = {1'b0, r_drop} + 9'(r_count);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else if (bus.Flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; outputs are masked whenever the buffer is empty.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= '{pc: bus.PC, inst: bus.InstIn};
  end

  assign w_head         = r_mem[r_rptr];
  assign bus.FetchReady = w_ready;
  assign bus.Halt       = ~w_ready;
  assign bus.InstValid  = w_valid;
  assign bus.InstOut    = w_valid ? w_head.inst : '0;
  assign bus.PCOut      = w_valid ? w_head.pc   : '0;
  assign bus.Count      = r_count;
  assign bus.DropCnt    = r_drop;
endmodule

// File: tb/tb_inst_buffer.sv
// Random + directed bench for inst_buffer against a queue-based reference.
module tb_inst_buffer;
  localparam int IW    = 9;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  bit   cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  inst_buffer_if #(.IW(IW), .DEPTH(DEPTH)) bus ();
  inst_buffer #(.IW(IW), .DEPTH(DEPTH)) dut (.CLK(CLK), .Reset(Reset), .bus(bus.slave));

  typedef struct packed {
    logic [15:0]   pc;
    logic [IW-1:0] inst;
  } ent_t;

  ent_t m_q[$];
  int   m_drop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of whole entries plus a saturating integer.
  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_q.delete();
      m_drop = 0;
    end else if (bus.Flush) begin
      m_drop = (m_drop + m_q.size() > 255) ? 255 : m_drop + m_q.size();
      m_q.delete();
    end else begin
      int  n;
      bit  do_pop, do_push;
      n       = m_q.size();
      do_pop  = (n != 0) && bus.DecodeReady;
      do_push = (n < DEPTH) && bus.FetchValid;
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back('{pc: bus.PC, inst: bus.InstIn});
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      int   n;
      ent_t h;
      n = m_q.size();
      h = (n != 0) ? m_q[0] : '0;
      chk("count",      32'(bus.Count),      32'(n));
      chk("fetchready", 32'(bus.FetchReady), 32'(n < DEPTH));
      chk("halt",       32'(bus.Halt),       32'(n >= DEPTH));
      chk("instvalid",  32'(bus.InstValid),  32'(n != 0));
      chk("instout",    32'(bus.InstOut),    32'(h.inst));
      chk("pcout",      32'(bus.PCOut),      32'(h.pc));
      chk("dropcnt",    32'(bus.DropCnt),    32'(m_drop));
    end
  end

  // Drive inputs just after a falling edge, then advance one full cycle.
  task automatic tick(input bit fv, input int pc, input int inst, input bit dr, input bit fl);
    bus.FetchValid  = fv;
    bus.PC          = 16'(pc);
    bus.InstIn      = IW'(inst);
    bus.DecodeReady = dr;
    bus.Flush       = fl;
    @(negedge CLK);
    #1;
  endtask

  int popped[$];

  initial begin
    Reset = 1'b1;
    bus.FetchValid = 0; bus.PC = 0; bus.InstIn = 0; bus.DecodeReady = 0; bus.Flush = 0;
    @(negedge CLK); #1;
    chk("rst_count", 32'(bus.Count), 0);
    chk("rst_ready", 32'(bus.FetchReady), 1);
    chk("rst_halt",  32'(bus.Halt), 0);
    chk("rst_valid", 32'(bus.InstValid), 0);
    chk("rst_inst",  32'(bus.InstOut), 0);
    chk("rst_drop",  32'(bus.DropCnt), 0);
    Reset = 1'b0;
    cmp_en = 1'b1;

    // Async reset between edges with two entries held
    tick(1, 16'h50, 9'h0AA, 0, 0);
    tick(1, 16'h51, 9'h0AB, 0, 0);
    chk("ar_pre_count", 32'(bus.Count), 2);
    bus.FetchValid = 0;
    #2 Reset = 1'b1;
    #1;
    chk("ar_count", 32'(bus.Count), 0);
    chk("ar_valid", 32'(bus.InstValid), 0);
    chk("ar_ready", 32'(bus.FetchReady), 1);
    chk("ar_drop",  32'(bus.DropCnt), 0);
    @(negedge CLK); #1;
    Reset = 1'b0;

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) tick(1, i, 9'h101 + i, 0, 0);
    chk("fill_count", 32'(bus.Count), 4);
    chk("fill_ready", 32'(bus.FetchReady), 0);
    chk("fill_halt",  32'(bus.Halt), 1);
    chk("fill_inst",  32'(bus.InstOut), 32'h101);
    chk("fill_pc",    32'(bus.PCOut), 0);

    // Full plus pop: the offered word must be dropped
    tick(1, 16'h99, 9'h1AA, 1, 0);
    chk("fp_count", 32'(bus.Count), 3);
    chk("fp_inst",  32'(bus.InstOut), 32'h102);

    // Flush together with push and pop
    tick(1, 16'h77, 9'h077, 1, 1);
    chk("fl_count", 32'(bus.Count), 0);
    chk("fl_valid", 32'(bus.InstValid), 0);
    chk("fl_inst",  32'(bus.InstOut), 0);
    chk("fl_drop",  32'(bus.DropCnt), 3);
    tick(0, 0, 0, 0, 1);
    chk("fl_empty_drop", 32'(bus.DropCnt), 3);

    // Wrap-around: pop every cycle from the second push on
    tick(1, 0, 9'h000, 0, 0);
    for (int i = 1; i < 10; i++) begin
      if (bus.InstValid) popped.push_back(int'(bus.PCOut));
      tick(1, i, i, 1, 0);
      chk("wrap_cnt_le2", 32'(bus.Count <= 2), 1);
    end
    for (int k = 0; k < 8 && bus.InstValid; k++) begin
      popped.push_back(int'(bus.PCOut));
      tick(0, 0, 0, 1, 0);
    end
    chk("wrap_npop", 32'(popped.size()), 10);
    for (int i = 0; i < popped.size(); i++) chk("wrap_order", 32'(popped[i]), 32'(i));

    // Saturation of the drop counter (starts at 3)
    for (int r = 0; r < 87; r++) begin
      for (int i = 0; i < 4; i++) tick(1, i, i, 0, 0);
      tick(0, 0, 0, 0, 1);
      if (r == 9)  chk("sat_10",  32'(bus.DropCnt), 43);
      if (r == 85) chk("sat_86",  32'(bus.DropCnt), 255);
      if (r == 86) chk("sat_hold", 32'(bus.DropCnt), 255);
    end

    // Random traffic with occasional flush and mid-cycle reset
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 16'hFFFF),
           $urandom_range(0, 511), $urandom_range(0, 2) != 0,
           $urandom_range(0, 20) == 0);
      if ($urandom_range(0, 400) == 0) begin
        #2 Reset = 1'b1;
        @(negedge CLK); #1;
        Reset = 1'b0;
      end
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
